// File: rtl/ps2_dev_tx_apb.sv
// Purpose: APB-programmed PS/2 device-side (keyboard) transmitter with a byte FIFO.
// Latency: DATA write in cycle T -> start bit on ps2_data from cycle T+2 when idle and empty.
// Backpressure: none on APB (pready=1); a push into a full FIFO with no pop is dropped and sets sticky ovf.
//
// Ports:
//   clock, reset        system clock; synchronous active-low reset
//   in_p*               zero-wait-state APB slave (only paddr[3:0], pstrb[0] decoded)
//   ps2_clk, ps2_data   PS/2 device-to-host frame lines, idle high
// Registers: 0x0 DATA (W), 0x4 STATUS (R, bit3 write-1-to-clear), 0x8 CTRL (optional).
// Optional feature: define PS2_TX_PARITY_ERR_EN to add CTRL.bad_par (parity inversion).
module ps2_dev_tx_apb #(
  parameter int CLK_DIV = 16,
  parameter int FIFO_AW = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic [2:0]  in_pprot,
  input  logic        in_pwrite,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  output logic        ps2_clk,
  output logic        ps2_data
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [15:0] HALF_LAST = 16'(CLK_DIV - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]         state;
  logic [15:0]        div_cnt;
  logic               half;      // 0: ps2_clk high half of a cell, 1: low half
  logic [3:0]         bit_idx;
  logic [10:0]        frame;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               ovf;
  logic               bad_par;

  logic wr_acc;
  logic push;
  logic pop;
  logic push_ok;
  logic push_drop;
  logic ovf_clr;
  logic full;
  logic empty;
  logic half_end;
  logic par;
  logic [7:0]  head;
  logic [31:0] status;
  logic        unused_ok;

  assign in_pready  = 1'b1;
  assign in_pslverr = 1'b0;

  assign wr_acc    = in_psel && in_penable && in_pwrite;
  assign push      = wr_acc && (in_paddr[3:0] == 4'h0) && in_pstrb[0];
  assign ovf_clr   = wr_acc && (in_paddr[3:0] == 4'h4) && in_pwdata[3];

  assign full      = (count == (FIFO_AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign pop       = (state == ST_IDLE) && !empty;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push_ok   = push && (!full || pop);
  assign push_drop = push && full && !pop;

  assign half_end  = (div_cnt == HALF_LAST);
  assign head      = mem[rd_ptr];

`ifdef PS2_TX_PARITY_ERR_EN
  assign par = ~^head ^ bad_par;
`else
  assign par = ~^head;
  assign bad_par = 1'b0;
`endif

  assign unused_ok = ^{in_pprot, in_paddr[31:4], in_pwdata[31:8], in_pstrb[3:1], bad_par};

  // Lines are decoded straight from state so reset shows idle levels on the next cycle.
  assign ps2_data = (state == ST_SEND) ? frame[bit_idx] : 1'b1;
  assign ps2_clk  = !((state == ST_SEND) && half);

  always_comb begin
    status = '0;
    status[0] = (state != ST_IDLE);
    status[1] = full;
    status[2] = empty;
    status[3] = ovf;
    status[8+FIFO_AW:8] = count;
  end

  always_comb begin
    in_prdata = '0;
    if (in_psel && !in_pwrite) begin
      case (in_paddr[3:0])
        4'h4:    in_prdata = status;
`ifdef PS2_TX_PARITY_ERR_EN
        4'h8:    in_prdata = {31'd0, bad_par};
`endif
        default: in_prdata = '0;
      endcase
    end
  end

  // Storage is not reset; pointers and count define validity.
  always_ff @(posedge clock) begin
    if (reset && push_ok) mem[wr_ptr] <= in_pwdata[7:0];
  end

`ifdef PS2_TX_PARITY_ERR_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      bad_par <= 1'b0;
    end else if (wr_acc && (in_paddr[3:0] == 4'h8)) begin
      bad_par <= in_pwdata[0];
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      state   <= ST_IDLE;
      div_cnt <= '0;
      half    <= 1'b0;
      bit_idx <= '0;
      frame   <= '1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{FIFO_AW{1'b0}}, push_ok} - {{FIFO_AW{1'b0}}, pop};

      if (push_drop)    ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (pop) begin
            frame   <= {1'b1, par, head, 1'b0};
            bit_idx <= '0;
            div_cnt <= '0;
            half    <= 1'b0;
            state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (half_end) begin
            div_cnt <= '0;
            half    <= ~half;
            if (half) begin
              if (bit_idx == 4'd10) state <= ST_GAP;
              else                  bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          // Two half-cells of idle levels separate consecutive frames.
          if (half_end) begin
            div_cnt <= '0;
            half    <= ~half;
            if (half) state <= ST_IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_dev_tx_apb.sv
module tb_ps2_dev_tx_apb;

  localparam int CD    = 4;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic        clock;
  logic        reset;
  logic [31:0] in_paddr;
  logic        in_psel;
  logic        in_penable;
  logic [2:0]  in_pprot;
  logic        in_pwrite;
  logic [31:0] in_pwdata;
  logic [3:0]  in_pstrb;
  logic        in_pready;
  logic [31:0] in_prdata;
  logic        in_pslverr;
  logic        ps2_clk;
  logic        ps2_data;

  int total;
  int bad;
  int frames_seen;
  bit bad_par_m;
  logic [10:0] exp_q[$];

  ps2_dev_tx_apb #(.CLK_DIV(CD), .FIFO_AW(AW)) dut (
    .clock(clock), .reset(reset),
    .in_paddr(in_paddr), .in_psel(in_psel), .in_penable(in_penable),
    .in_pprot(in_pprot), .in_pwrite(in_pwrite), .in_pwdata(in_pwdata),
    .in_pstrb(in_pstrb), .in_pready(in_pready), .in_prdata(in_prdata),
    .in_pslverr(in_pslverr), .ps2_clk(ps2_clk), .ps2_data(ps2_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, parity making the total count of ones odd
  // (or even when the error-injection bit is set), stop 1.
  function automatic logic [10:0] ref_frame(input logic [7:0] d, input bit bp);
    logic [10:0] f;
    int ones;
    ones = $countones(d);
    f = '0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    f[9]  = ((ones % 2) == 0) ? 1'b1 : 1'b0;
    if (bp) f[9] = ~f[9];
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    @(posedge clock); #1;
    in_psel = 1'b1; in_penable = 1'b0; in_pwrite = 1'b1;
    in_paddr = addr; in_pwdata = data; in_pstrb = strb; in_pprot = 3'($urandom);
    @(posedge clock); #1;
    in_penable = 1'b1;
    @(posedge clock); #1;
    in_psel = 1'b0; in_penable = 1'b0; in_pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    @(posedge clock); #1;
    in_psel = 1'b1; in_penable = 1'b0; in_pwrite = 1'b0; in_paddr = addr;
    @(posedge clock); #1;
    in_penable = 1'b1;
    @(negedge clock);
    data = in_prdata;
    if (in_pready !== 1'b1 || in_pslverr !== 1'b0) begin
      chk("pready_pslverr", {30'd0, in_pready, in_pslverr}, 32'h2);
    end
    @(posedge clock); #1;
    in_psel = 1'b0; in_penable = 1'b0;
  endtask

  task automatic wait_idle();
    logic [31:0] s;
    bit done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      apb_read(32'h4, s);
      if (s == 32'h4) done = 1'b1;
    end
    chk("idle_reached", {31'd0, done}, 32'd1);
  endtask

  // Writes n DATA bytes back-to-back to an idle, empty block. The first accepted byte
  // leaves at once, the next DEPTH fill the FIFO, the rest are dropped.
  task automatic burst(input int n, input bit rnd, input logic [7:0] base);
    int acc;
    int cnt;
    bit drop;
    logic [7:0] d;
    logic [3:0] st;
    logic [31:0] s;
    logic [31:0] e;
    acc = 0; drop = 1'b0;
    for (int i = 0; i < n; i++) begin
      d  = rnd ? 8'($urandom) : base + 8'(i);
      st = rnd ? 4'($urandom) : 4'hF;
      if (rnd && $urandom_range(0, 3) != 0) st[0] = 1'b1;
      apb_write(32'h0, {($urandom & 32'hFFFFFF00), 8'h0} | {24'd0, d}, st);
      if (st[0]) begin
        if (acc < DEPTH + 1) begin
          exp_q.push_back(ref_frame(d, bad_par_m));
          acc++;
        end else begin
          drop = 1'b1;
        end
      end
    end
    cnt = (acc > 0) ? acc - 1 : 0;
    e = 32'(cnt) << 8;
    if (acc > 0)      e |= 32'h1;
    if (cnt == DEPTH) e |= 32'h2;
    if (cnt == 0)     e |= 32'h4;
    if (drop)         e |= 32'h8;
    apb_read(32'h4, s);
    chk("status_after_burst", s, e);
    if (drop) begin
      apb_write(32'h4, 32'h8 | ($urandom & 32'hFFFFFFF0), 4'($urandom));
      apb_read(32'h4, s);
      chk("ovf_cleared", s, e & ~32'h8);
    end
  endtask

  // Scoreboard monitor: decodes frames from the PS/2 lines and compares against the queue.
  initial begin : mon
    int idle_run;
    bit have_prev;
    bit idle_bad;
    bit tim_ok;
    bit abort;
    logic [10:0] got;
    logic [10:0] exp;
    idle_run = 0; have_prev = 1'b0; idle_bad = 1'b0;
    forever begin
      @(negedge clock);
      if (reset !== 1'b1) begin
        have_prev = 1'b0; idle_run = 0; idle_bad = 1'b0;
        continue;
      end
      if (ps2_data === 1'b1) begin
        if (ps2_clk !== 1'b1) idle_bad = 1'b1;
        idle_run++;
        continue;
      end
      chk("idle_lines_high", {31'd0, idle_bad}, 32'd0);
      if (have_prev) chk("gap_long_enough", {31'd0, idle_run >= 2 * CD}, 32'd1);
      got = '1; tim_ok = 1'b1; abort = 1'b0;
      for (int b = 0; b < 11 && !abort; b++) begin
        for (int c = 0; c < 2 * CD; c++) begin
          if (!(b == 0 && c == 0)) @(negedge clock);
          if (reset !== 1'b1) begin abort = 1'b1; break; end
          if (c == 0) got[b] = ps2_data;
          else if (ps2_data !== got[b]) tim_ok = 1'b0;
          if (ps2_clk !== ((c < CD) ? 1'b1 : 1'b0)) tim_ok = 1'b0;
        end
      end
      idle_run = 0; idle_bad = 1'b0;
      if (abort) begin have_prev = 1'b0; continue; end
      frames_seen++;
      chk("cell_timing", {31'd0, tim_ok}, 32'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_frame", {21'd0, got}, 32'h0);
      end else begin
        exp = exp_q.pop_front();
        chk("frame_bits", {21'd0, got}, {21'd0, exp});
      end
      have_prev = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] s;
    int fb;
    total = 0; bad = 0; frames_seen = 0; bad_par_m = 1'b0;
    reset = 1'b0; in_paddr = '0; in_psel = 1'b0; in_penable = 1'b0;
    in_pprot = '0; in_pwrite = 1'b0; in_pwdata = '0; in_pstrb = '0;
    repeat (4) @(posedge clock);
    #1 reset = 1'b1;

    // Reset state
    @(negedge clock);
    chk("reset_ps2_clk", {31'd0, ps2_clk}, 32'd1);
    chk("reset_ps2_data", {31'd0, ps2_data}, 32'd1);
    apb_read(32'h4, s);
    chk("reset_status", s, 32'h4);

    // 0x1C: latency and busy during frame
    exp_q.push_back(ref_frame(8'h1C, 1'b0));
    apb_write(32'h0, 32'h1C, 4'h1);
    @(negedge clock);
    chk("start_T+1", {31'd0, ps2_data}, 32'd1);
    @(negedge clock);
    chk("start_T+2", {31'd0, ps2_data}, 32'd0);
    apb_read(32'h4, s);
    chk("status_busy", s, 32'h5);
    wait_idle();

    // 0xF0
    exp_q.push_back(ref_frame(8'hF0, 1'b0));
    apb_write(32'h0, 32'hF0, 4'h1);
    wait_idle();

    // Overflow burst 0x01..0x0A
    burst(10, 1'b0, 8'h01);
    wait_idle();

    // Unused offsets and pstrb[0]=0 write
    apb_write(32'h0, 32'h55, 4'hE);
    apb_read(32'h4, s);
    chk("no_push_strb0", s, 32'h4);
    apb_read(32'hC, s);
    chk("read_0xC", s, 32'h0);
    apb_read(32'h0, s);
    chk("read_DATA", s, 32'h0);

    // Randomized bursts
    for (int k = 0; k < 6; k++) begin
      burst($urandom_range(1, DEPTH + 3), 1'b1, 8'h00);
      wait_idle();
    end

    // Reset mid-frame with 3 bytes queued
    burst(4, 1'b0, 8'hA0);
    repeat (34) @(posedge clock);
    #1 reset = 1'b0;
    exp_q.delete();
    fb = frames_seen;
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_ps2_clk", {31'd0, ps2_clk}, 32'd1);
    chk("rst_mid_ps2_data", {31'd0, ps2_data}, 32'd1);
    apb_read(32'h4, s);
    chk("rst_mid_status", s, 32'h4);
    repeat (300) @(posedge clock);
    chk("no_frames_after_reset", 32'(frames_seen), 32'(fb));

    // Parity error injection
    apb_write(32'h8, 32'h1, 4'hF);
    apb_read(32'h8, s);
`ifdef PS2_TX_PARITY_ERR_EN
    chk("ctrl_readback", s, 32'h1);
    bad_par_m = 1'b1;
`else
    chk("ctrl_readback", s, 32'h0);
`endif
    exp_q.push_back(ref_frame(8'h1C, bad_par_m));
    apb_write(32'h0, 32'h1C, 4'h1);
    wait_idle();
    apb_write(32'h8, 32'h0, 4'hF);
    bad_par_m = 1'b0;
    apb_read(32'h8, s);
    chk("ctrl_cleared", s, 32'h0);
    exp_q.push_back(ref_frame(8'h1C, bad_par_m));
    apb_write(32'h0, 32'h1C, 4'h1);
    wait_idle();

    repeat (10) @(posedge clock);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_dev_tx_apb.md
Name: ps2_dev_tx_apb

Overview:
- APB-programmed PS/2 device-side transmitter: the keyboard end of the PS/2 link.
- CPU writes scancode bytes into a FIFO. The block drives ps2_clk/ps2_data as an 11-bit PS/2 device-to-host frame per byte.
- Used as an in-SoC keyboard model feeding the PS/2 receiver peripheral, for simulation and loopback test.
- Zero-wait-state APB slave, one clock domain.

Parameters:
- CLK_DIV, 16, system clocks per PS/2 half-bit. Legal range 2..65535; internal counter is 16 bits.
- FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW (default 8).

Ports:
- clock  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-low reset (0 = reset)
- in_paddr  in  32  APB address; only [3:0] decoded
- in_psel  in  1  APB select
- in_penable  in  1  APB enable
- in_pprot  in  3  unused
- in_pwrite  in  1  APB write
- in_pwdata  in  32  APB write data
- in_pstrb  in  4  APB byte strobes; only [0] used
- in_pready  out  1  constant 1
- in_prdata  out  32  APB read data, combinational
- in_pslverr  out  1  constant 0
- ps2_clk  out  1  PS/2 clock to receiver, idle 1
- ps2_data  out  1  PS/2 data to receiver, idle 1

Behaviour:
- Access condition: psel & penable. Write access adds pwrite; read access adds !pwrite.
- Register map (paddr[3:0]):
  - 0x0 DATA, write-only. A write with pstrb[0]=1 pushes pwdata[7:0]. Reads return 0.
  - 0x4 STATUS, read-only except bit3:
    - bit0 busy (FSM not IDLE)
    - bit1 full
    - bit2 empty
    - bit3 ovf, sticky; cleared by a write to 0x4 with pwdata[3]=1
    - bits[8+FIFO_AW:8] FIFO count
    - other bits 0
  - 0x8 CTRL: see Optional Feature.
  - Other offsets: read 0, writes ignored.
- FIFO:
  - Push when not full, or when full and a pop occurs in the same cycle; count is unchanged in the latter case.
  - Push when full with no pop: byte dropped, ovf <= 1.
  - Push and clear of ovf in the same cycle is impossible (different addresses).
- FSM states: IDLE, SEND, GAP.
  - IDLE: ps2_clk=1, ps2_data=1. If FIFO not empty: pop and load frame = {stop=1, parity, d[7:0], start=0}; go to SEND with bit index 0 and divider 0.
  - SEND: each bit cell is 2*CLK_DIV cycles.
    - ps2_data = current frame bit for the whole cell.
    - ps2_clk = 1 for the first CLK_DIV cycles, 0 for the next CLK_DIV cycles.
    - Bits go out start, d0..d7 (LSB first), parity, stop.
    - After the cell for bit 10 ends: go to GAP.
  - GAP: ps2_clk=1, ps2_data=1 for 2*CLK_DIV cycles, then IDLE.
  - Frame period including GAP = 24*CLK_DIV cycles.
- Parity is odd: parity = ~^d[7:0].
- Latency: write access in cycle T to an idle block with empty FIFO gives ps2_data=0 (start bit) from cycle T+2.
- Data is stable across each ps2_clk falling edge; it changes only at cell boundaries while ps2_clk=1.
- Back-to-back frames are always separated by GAP.
- Reset (reset=0), including mid-frame, takes effect at the next clock edge:
  - FIFO emptied, ovf=0, FSM IDLE, counters 0.
  - ps2_clk=1, ps2_data=1.
  - in_prdata reflects reset state (STATUS = 0x4).
- No interrupt output; software polls STATUS.

Optional Feature:
- Macro PS2_TX_PARITY_ERR_EN.
- Defined: CTRL at 0x8, bit0 bad_par, R/W, reset 0.
  - When 1, the parity bit of frames loaded from then on is inverted (even parity), for receiver error-injection tests.
  - A frame already in flight keeps its parity.
- Undefined: 0x8 reads 0, writes ignored, parity always odd, no CTRL flop.

Test Plan:
- CLK_DIV=4, write 0x1C to 0x0 -> ps2_data=0 at T+2. Frame bits 0,0,0,1,1,1,0,0,0,0,1 (parity 0), each held 8 cycles. ps2_clk low cycles 4-7 of each cell. Then idle 1/1. busy=1 during frame, STATUS=0x4 after GAP.
- Write 0xF0 -> data bits 0,0,0,0,1,1,1,1, parity 1. Loopback into the PS/2 receiver peripheral reads back 0xF0.
- 10 back-to-back DATA writes 0x01..0x0A while idle:
  - 0x01 goes out immediately, 0x02..0x09 fill the FIFO, 0x0A is dropped.
  - STATUS: full=1, count=8, ovf=1.
  - Exactly 9 frames emitted in order 0x01..0x09.
  - Write 0x8 to 0x4 clears ovf.
- Assert reset=0 for one cycle during bit 5 of a frame with 3 bytes queued -> next cycle ps2_clk=1, ps2_data=1, STATUS=0x4, no further frames.
- With PS2_TX_PARITY_ERR_EN: set CTRL=1, write 0x1C -> parity bit 1. Clear CTRL, write 0x1C -> parity bit 0. Without the macro, CTRL reads 0 and parity stays 0.
- pstrb=0 write to 0x0 -> no push, count unchanged. Read of 0xC -> 0. in_pready=1 and in_pslverr=0 always.
